// File: rtl/nested_ifs_cfg_loader.sv
// Framed configuration loader for the nested_ifs atom: shadows a 13-word frame and
// commits it to the active registers in one edge at a safe (atom idle) point.
module nested_ifs_cfg_loader #(
    parameter bit WAIT_IDLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_data,
    input  logic        cfg_last,
    input  logic        atom_idle,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [31:0] cons_1,
    output logic [31:0] cons_2,
    output logic [31:0] cons_3,
    output logic [31:0] cons_4,
    output logic [31:0] cons_5,
    output logic [31:0] cons_6,
    output logic [31:0] cons_7,
    output logic [31:0] cons_8,
    output logic [31:0] cons_9,
    output logic [31:0] cons_10,
    output logic [31:0] cons_11,
    output logic        sel_1,
    output logic        sel_2,
    output logic        sel_3,
    output logic        sel_4,
    output logic        sel_5,
    output logic        sel_6,
    output logic        sel_7,
    output logic [1:0]  sel_8,
    output logic [1:0]  sel_9,
    output logic        sel_10,
    output logic [1:0]  sel_11,
    output logic [1:0]  sel_12,
    output logic        sel_13,
    output logic        sel_14,
    output logic        sel_15,
    output logic        sel_16,
    output logic [1:0]  sel_17,
    output logic [1:0]  sel_18,
    output logic        sel_19,
    output logic [1:0]  sel_20,
    output logic [1:0]  sel_21,
    output logic [1:0]  rel_op1,
    output logic [1:0]  rel_op2,
    output logic [1:0]  rel_op3
);

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StCommit} state_e;

    state_e      r_state;
    logic [3:0]  r_idx;
    logic [31:0] r_sh_cons [11];
    logic [28:0] r_sh_sel;
    logic [5:0]  r_sh_ops;
    logic [31:0] r_cons [11];
    logic [28:0] r_sel;
    logic [5:0]  r_ops;
    logic        r_done;
    logic        r_err;

    logic w_accept;
    logic w_final_slot;
    logic w_commit_ok;

    // Ready is held low while reset is asserted so no word is taken during reset.
    assign cfg_ready    = ~rst & (r_state != StCommit);
    assign w_accept     = cfg_valid & cfg_ready;
    assign w_final_slot = (r_idx == 4'd12);
    assign w_commit_ok  = !WAIT_IDLE || atom_idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_idx   <= 4'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_sel   <= '0;
            r_ops   <= '0;
            for (int i = 0; i < 11; i++) begin
                r_cons[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            if (w_accept && (r_state != StDrain)) begin
                if (r_idx < 4'd11) begin
                    r_sh_cons[r_idx] <= cfg_data;
                end else if (r_idx == 4'd11) begin
                    r_sh_sel <= cfg_data[28:0];
                end else begin
                    r_sh_ops <= cfg_data[5:0];
                end
            end

            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        if (cfg_last) begin
                            r_err <= 1'b1;
                        end else begin
                            r_idx   <= 4'd1;
                            r_state <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (w_accept) begin
                        if (cfg_last) begin
                            r_idx   <= 4'd0;
                            r_state <= w_final_slot ? StCommit : StIdle;
                            r_err   <= !w_final_slot;
                        end else if (w_final_slot) begin
                            r_idx   <= 4'd0;
                            r_err   <= 1'b1;
                            r_state <= StDrain;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                StDrain: begin
                    if (w_accept && cfg_last) begin
                        r_state <= StIdle;
                    end
                end
                StCommit: begin
                    if (w_commit_ok) begin
                        for (int i = 0; i < 11; i++) begin
                            r_cons[i] <= r_sh_cons[i];
                        end
                        r_sel   <= r_sh_sel;
                        r_ops   <= r_sh_ops;
                        r_done  <= 1'b1;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign cfg_done = r_done;
    assign cfg_err  = r_err;

    assign cons_1  = r_cons[0];
    assign cons_2  = r_cons[1];
    assign cons_3  = r_cons[2];
    assign cons_4  = r_cons[3];
    assign cons_5  = r_cons[4];
    assign cons_6  = r_cons[5];
    assign cons_7  = r_cons[6];
    assign cons_8  = r_cons[7];
    assign cons_9  = r_cons[8];
    assign cons_10 = r_cons[9];
    assign cons_11 = r_cons[10];

    assign sel_1  = r_sel[0];
    assign sel_2  = r_sel[1];
    assign sel_3  = r_sel[2];
    assign sel_4  = r_sel[3];
    assign sel_5  = r_sel[4];
    assign sel_6  = r_sel[5];
    assign sel_7  = r_sel[6];
    assign sel_8  = r_sel[8:7];
    assign sel_9  = r_sel[10:9];
    assign sel_10 = r_sel[11];
    assign sel_11 = r_sel[13:12];
    assign sel_12 = r_sel[15:14];
    assign sel_13 = r_sel[16];
    assign sel_14 = r_sel[17];
    assign sel_15 = r_sel[18];
    assign sel_16 = r_sel[19];
    assign sel_17 = r_sel[21:20];
    assign sel_18 = r_sel[23:22];
    assign sel_19 = r_sel[24];
    assign sel_20 = r_sel[26:25];
    assign sel_21 = r_sel[28:27];

    assign rel_op1 = r_ops[1:0];
    assign rel_op2 = r_ops[3:2];
    assign rel_op3 = r_ops[5:4];

endmodule
